apb_wait_slave: RTL and testbench
=================================

Name: apb_wait_slave

Overview:
- Parametrised APB3 completer: register-file memory behind an APB port, with programmable wait states, address-range/alignment error response and protocol-violation detection.
- Replaces the fixed 32-bit, zero-wait DUT behind the existing APB bench interface.
- Sits as the DUT driven by the bench driver/monitor; also reusable as a generic peripheral register bank.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; legal values 8, 16, 32, 64.
- DEPTH, 16, number of DATA_WIDTH words implemented; legal values 1 to 1024.
- WAIT_CYCLES, 2, pready wait states inserted in the ACCESS phase; legal values 0 to 15.

Ports:
- pclk, input, 1, APB clock; all state changes on its rising edge.
- preset, input, 1, asynchronous active-low reset.
- psel, input, 1, completer select.
- penable, input, 1, ACCESS-phase strobe.
- pwrite, input, 1, 1 = write, 0 = read.
- paddr, input, ADDR_WIDTH, byte address.
- pwdata, input, DATA_WIDTH, write data.
- pstrb, input, DATA_WIDTH/8, byte strobes; present only with APB_PSTRB_EN.
- prdata, output, DATA_WIDTH, read data.
- pready, output, 1, transfer completes this cycle.
- pslverr, output, 1, error response; valid only while pready = 1.
- proto_err, output, 1, sticky protocol-violation flag.

Behaviour:
- Reset (preset = 0, asynchronous):
  - state = IDLE; wait counter = 0.
  - pready, pslverr and proto_err = 0; prdata = 0.
  - All memory words = 0.
  - Reset in the middle of a transfer aborts it with no memory update.
- Derived values:
  - word index = paddr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)].
  - misaligned = low log2(DATA_WIDTH/8) bits of paddr are nonzero.
  - err = misaligned, or word index >= DEPTH.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - psel = 1 and penable = 0 at an edge: latch paddr, pwrite, pwdata (and pstrb), compute err_q, load counter = WAIT_CYCLES, go to ACCESS.
  - psel = 1 and penable = 1 at an edge (ACCESS without SETUP): set proto_err, stay in IDLE, no response.
- ACCESS:
  - pready = 1 (combinational) when counter = 0; otherwise the counter decrements each edge.
  - Edge with psel = 1, penable = 1 and pready = 1 completes the transfer:
    - Write with err_q = 0: mem[index] <= latched pwdata.
    - Any transfer returns to IDLE.
  - Edge with psel = 0 before completion: abort, set proto_err, no write, go to IDLE.
  - Change of paddr, pwrite or pwdata during ACCESS versus the latched values: set proto_err. The latched values remain authoritative.
- pslverr = pready AND err_q. An erroring write leaves memory unchanged.
- prdata:
  - Equals mem[index_q] while pready = 1, pwrite_q = 0 and err_q = 0; otherwise 0.
  - Read-after-write to the same word in back-to-back transfers returns the new data.
- Latency:
  - Minimum transfer = 2 cycles (SETUP + ACCESS) with WAIT_CYCLES = 0.
  - General transfer = 2 + WAIT_CYCLES cycles.
  - Back-to-back transfers are supported: after completion, the next SETUP is sampled from IDLE.
- proto_err clears only on reset.

Optional Feature:
- Macro: APB_PSTRB_EN.
- Defined:
  - The pstrb port exists and is latched in SETUP.
  - A write updates only the bytes whose strobe bit is 1.
  - pstrb = 0 on a write is a legal no-op (pslverr = 0).
  - On reads, pstrb != 0 sets proto_err.
- Undefined: no pstrb port; writes update the full word.

Decomposition:
- Package apb_wait_pkg holds:
  - typedef enum for the FSM states (IDLE, ACCESS).
  - localparam functions for strobe width (DATA_WIDTH/8) and byte-offset bits (log2 of strobe width).
  - Counter width constant: 4 bits.
- One sub-module, apb_wait_mem: DEPTH x DATA_WIDTH storage with async clear, byte-enable write port and combinational read port.
- FSM, error decode and proto_err logic stay in the top level.

Test Plan:
- Reset then write with WAIT_CYCLES = 2:
  - Stimulus: write 0xDEADBEEF to 0x08, then read 0x08.
  - Required: pready high on the 3rd ACCESS cycle; each transfer takes 4 cycles; read returns prdata = 0xDEADBEEF; pslverr = 0.
- Out-of-range and misaligned accesses with DEPTH = 16:
  - Stimulus: write 0x12345678 to 0x40; read 0x40; write to 0x02.
  - Required: each completes with pslverr = 1; read returns prdata = 0; mem[0] stays 0.
- Protocol violations:
  - penable = 1 without SETUP -> proto_err = 1 and no pready.
  - psel dropped mid-wait -> abort, no write.
  - proto_err stays 1 until preset = 0.
- Zero-wait back-to-back with WAIT_CYCLES = 0:
  - Stimulus: write 0xA5 to 0x0, then read 0x0 immediately.
  - Required: each transfer takes 2 cycles; read returns 0xA5.
- Reset mid-ACCESS:
  - Stimulus: assert preset = 0 during a write to 0x04.
  - Required: pready = 0 immediately; a later read of 0x04 returns 0.
- Strobes (APB_PSTRB_EN defined):
  - Stimulus: write 0xFFFFFFFF, then write 0x00000000 with pstrb = 4'b0101.
  - Required: read returns 0xFF00FF00.

Source files
------------

// File: rtl/apb_wait_pkg.sv
// Shared types and width helpers for the apb_wait_slave register bank.
package apb_wait_pkg;

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam int unsigned CNT_W = 4;

   function automatic int unsigned strb_w(input int unsigned dw);
      return dw / 8;
   endfunction

   function automatic int unsigned off_bits(input int unsigned dw);
      return $clog2(dw / 8);
   endfunction

endpackage

// File: rtl/apb_wait_mem.sv
// DEPTH x DATA_WIDTH word store: async clear, byte-enable write, combinational read.
module apb_wait_mem #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned IDX_W      = 4
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic                    we,
   input  logic [IDX_W-1:0]        idx,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int unsigned SW = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  in_range;

   assign in_range = (32'(idx) < 32'(DEPTH));

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we && in_range) begin
         for (int unsigned b = 0; b < SW; b++)
            if (wstrb[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
   end

   always_comb begin
      rdata = '0;
      if (in_range) rdata = mem[idx];
   end

endmodule

// File: rtl/apb_wait_slave.sv
// APB3 completer register bank with programmable wait states and protocol checking.
// Define APB_PSTRB_EN to add the pstrb port and byte-masked writes.
module apb_wait_slave
   import apb_wait_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                          pclk,
   input  logic                          preset,
   input  logic                          psel,
   input  logic                          penable,
   input  logic                          pwrite,
   input  logic [ADDR_WIDTH-1:0]         paddr,
   input  logic [DATA_WIDTH-1:0]         pwdata,
`ifdef APB_PSTRB_EN
   input  logic [strb_w(DATA_WIDTH)-1:0] pstrb,
`endif
   output logic [DATA_WIDTH-1:0]         prdata,
   output logic                          pready,
   output logic                          pslverr,
   output logic                          proto_err
);

   localparam int unsigned SW    = strb_w(DATA_WIDTH);
   localparam int unsigned OB    = off_bits(DATA_WIDTH);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OB) - 64'd1);

   state_t                  state, state_n;
   logic [CNT_W-1:0]        cnt;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [IDX_W-1:0]        idx_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    err_q;
   logic [SW-1:0]           wstrb;
   logic [ADDR_WIDTH-1:0]   word_idx;
   logic                    err_d, start, proto_set, mem_we;
   logic [DATA_WIDTH-1:0]   mem_rdata;

   assign word_idx = paddr >> OB;
   assign err_d    = (|(paddr & OFF_MASK)) || (word_idx >= ADDR_WIDTH'(DEPTH));

`ifdef APB_PSTRB_EN
   logic [SW-1:0] strb_q;
   assign wstrb = strb_q;

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset)    strb_q <= '0;
      else if (start) strb_q <= pstrb;
   end
`else
   assign wstrb = '1;
`endif

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state     <= IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         idx_q     <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         state <= state_n;
         if (start) begin
            cnt     <= CNT_W'(WAIT_CYCLES);
            addr_q  <= paddr;
            idx_q   <= word_idx[IDX_W-1:0];
            write_q <= pwrite;
            wdata_q <= pwdata;
            err_q   <= err_d;
         end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (proto_set) proto_err <= 1'b1;
      end
   end

   always_comb begin
      state_n   = state;
      start     = 1'b0;
      proto_set = 1'b0;
      pready    = 1'b0;
      mem_we    = 1'b0;
      case (state)
         IDLE: begin
            if (psel && !penable) begin
               start   = 1'b1;
               state_n = ACCESS;
`ifdef APB_PSTRB_EN
               if (!pwrite && pstrb != '0) proto_set = 1'b1;
`endif
            end else if (psel && penable) begin
               proto_set = 1'b1;
            end
         end
         ACCESS: begin
            pready = (cnt == '0);
            if (!psel) begin
               proto_set = 1'b1;
               state_n   = IDLE;
            end else begin
               // Bus must hold the SETUP values; the latched copy still drives the transfer.
               if (paddr != addr_q || pwrite != write_q || pwdata != wdata_q) proto_set = 1'b1;
               if (penable && pready) begin
                  mem_we  = write_q && !err_q;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign pslverr = pready && err_q;
   assign prdata  = (pready && !write_q && !err_q) ? mem_rdata : '0;

   apb_wait_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W)
   ) u_mem (
      .pclk   (pclk),
      .preset (preset),
      .we     (mem_we),
      .idx    (idx_q),
      .wstrb  (wstrb),
      .wdata  (wdata_q),
      .rdata  (mem_rdata)
   );

endmodule

// File: tb/tb_apb_wait_slave.sv
// Bench for apb_wait_slave: a zero-wait and a two-wait instance share one APB bus.
module tb_apb_wait_slave;

   logic        pclk = 1'b0;
   logic        preset = 1'b0;
   logic [1:0]  psel;
   logic        penable, pwrite;
   logic [31:0] paddr, pwdata;
`ifdef APB_PSTRB_EN
   logic [3:0]  pstrb;
`endif

   logic [31:0] prdata_w  [2];
   logic        pready_w  [2];
   logic        pslverr_w [2];
   logic        proto_w   [2];

   // expected outputs per instance, and the expected memory image
   logic        exp_rdy   [2];
   logic        exp_err   [2];
   logic [31:0] exp_rd    [2];
   logic        exp_proto [2];
   logic [31:0] mm [2][16];

   int errors = 0;
   int checks = 0;

   always #5 pclk = ~pclk;

   apb_wait_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
      .pclk(pclk), .preset(preset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
      .pstrb(pstrb),
`endif
      .prdata(prdata_w[0]), .pready(pready_w[0]), .pslverr(pslverr_w[0]), .proto_err(proto_w[0]));

   apb_wait_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(2)) u_w2 (
      .pclk(pclk), .preset(preset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata),
`ifdef APB_PSTRB_EN
      .pstrb(pstrb),
`endif
      .prdata(prdata_w[1]), .pready(pready_w[1]), .pslverr(pslverr_w[1]), .proto_err(proto_w[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_idle(input int i);
      exp_rdy[i] = 1'b0;
      exp_err[i] = 1'b0;
      exp_rd[i]  = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         set_idle(i);
         exp_proto[i] = 1'b0;
         for (int k = 0; k < 16; k++) mm[i][k] = '0;
      end
   endtask

   always @(negedge pclk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("pready[%0d]", i),    32'(pready_w[i]),  32'(exp_rdy[i]));
         chk($sformatf("pslverr[%0d]", i),   32'(pslverr_w[i]), 32'(exp_err[i]));
         chk($sformatf("prdata[%0d]", i),    prdata_w[i],       exp_rd[i]);
         chk($sformatf("proto_err[%0d]", i), 32'(proto_w[i]),   32'(exp_proto[i]));
      end
   end

   // One transfer on instance i; abort_at >= 0 drops psel in that ACCESS cycle.
   task automatic xfer(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int abort_at,
                       output logic [31:0] rd, output bit serr, output int cyc);
      int wt;
      bit err, seen;
      wt   = (i == 0) ? 0 : 2;
      err  = (a[1:0] != 2'b00) || ((a >> 2) >= 32'd16);
      rd   = '0;
      serr = 1'b0;
      seen = 1'b0;
      cyc  = 1;
      psel[i] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
`ifdef APB_PSTRB_EN
      pstrb = s;
`endif
      @(posedge pclk); #1;
      penable = 1'b1;
      for (int j = 0; j < 20 && !seen; j++) begin
         if (j == abort_at) begin psel[i] = 1'b0; penable = 1'b0; end
         exp_rdy[i] = (j == wt);
         exp_err[i] = (j == wt) && err;
         exp_rd[i]  = (j == wt && !wr && !err) ? mm[i][a[5:2]] : '0;
         @(negedge pclk);
         cyc++;
         if (pready_w[i] && j != abort_at) begin
            seen = 1'b1; rd = prdata_w[i]; serr = pslverr_w[i];
         end
         @(posedge pclk); #1;
         if (j == abort_at) begin
            exp_proto[i] = 1'b1;
            set_idle(i);
            return;
         end
      end
      psel[i] = 1'b0; penable = 1'b0;
      set_idle(i);
      if (!seen) chk("pready_timeout", 32'd0, 32'd1);
      else if (wr && !err)
         for (int b = 0; b < 4; b++) if (s[b]) mm[i][a[5:2]][b*8 +: 8] = d[b*8 +: 8];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      bit serr;
      int cyc;
      psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APB_PSTRB_EN
      pstrb = '0;
`endif
      model_reset();
      repeat (3) @(posedge pclk);
      #1 preset = 1'b1;
      @(posedge pclk); #1;

      // wait-state write/read
      xfer(1, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, -1, rd, serr, cyc);
      chk("lat_wr_w2", cyc, 32'd4);
      chk("serr_wr_ok", 32'(serr), 32'd0);
      xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, -1, rd, serr, cyc);
      chk("lat_rd_w2", cyc, 32'd4);
      chk("rd_deadbeef", rd, 32'hDEADBEEF);

      // out-of-range and misaligned
      xfer(1, 1'b1, 32'h40, 32'h12345678, 4'hF, -1, rd, serr, cyc);
      chk("serr_oor_wr", 32'(serr), 32'd1);
      xfer(1, 1'b0, 32'h40, 32'h0, 4'h0, -1, rd, serr, cyc);
      chk("serr_oor_rd", 32'(serr), 32'd1);
      chk("rd_oor_zero", rd, 32'd0);
      xfer(1, 1'b1, 32'h02, 32'h11111111, 4'hF, -1, rd, serr, cyc);
      chk("serr_misaligned", 32'(serr), 32'd1);
      xfer(1, 1'b0, 32'h00, 32'h0, 4'h0, -1, rd, serr, cyc);
      chk("mem0_zero", rd, 32'd0);

      // zero-wait back-to-back
      xfer(0, 1'b1, 32'h00, 32'h000000A5, 4'hF, -1, rd, serr, cyc);
      chk("lat_wr_w0", cyc, 32'd2);
      xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, -1, rd, serr, cyc);
      chk("lat_rd_w0", cyc, 32'd2);
      chk("rd_a5", rd, 32'h000000A5);

      // ACCESS without SETUP
      psel[1] = 1'b1; penable = 1'b1;
      @(posedge pclk); #1;
      exp_proto[1] = 1'b1;
      psel[1] = 1'b0; penable = 1'b0;
      @(negedge pclk);
      chk("proto_noset", 32'(proto_w[1]), 32'd1);
      @(posedge pclk); #1;

      // psel dropped in the middle of the wait
      xfer(1, 1'b1, 32'h10, 32'h55555555, 4'hF, 1, rd, serr, cyc);
      xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, -1, rd, serr, cyc);
      chk("abort_no_write", rd, 32'd0);
      chk("proto_sticky", 32'(proto_w[1]), 32'd1);

`ifdef APB_PSTRB_EN
      xfer(0, 1'b1, 32'h0C, 32'hFFFFFFFF, 4'hF, -1, rd, serr, cyc);
      xfer(0, 1'b1, 32'h0C, 32'h00000000, 4'b0101, -1, rd, serr, cyc);
      xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, -1, rd, serr, cyc);
      chk("strobe_rd", rd, 32'hFF00FF00);
`endif

      // reset in the middle of a write
      psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hCAFEF00D;
`ifdef APB_PSTRB_EN
      pstrb = 4'hF;
`endif
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #2;
      preset = 1'b0;
      model_reset();
      #1;
      chk("pready_async_rst", 32'(pready_w[1]), 32'd0);
      chk("proto_cleared", 32'(proto_w[1]), 32'd0);
      psel = '0; penable = 1'b0;
      @(posedge pclk); #1;
      preset = 1'b1;
      @(posedge pclk); #1;
      xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, -1, rd, serr, cyc);
      chk("rst_abort_rd", rd, 32'd0);
      xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, -1, rd, serr, cyc);
      chk("rst_cleared_rd", rd, 32'd0);

      @(negedge pclk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
